// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage ARM-subset pipeline.
// Latency: the word at address A is on ifid_instr one edge after pc==A with ifid_le=1.
// Backpressure: pc_e=0 holds the PC and ifid_le=0 holds IF/ID; a taken branch still redirects.
//
// Optional build macro: FLUSH_ON_BRANCH_EN. When defined, a taken branch
// squashes the word fetched alongside it (IF/ID gets NOP_WORD, valid=0).
// When undefined, that word enters IF/ID as a delay slot.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pc_e                PC load enable (0 = load-use stall)
//   ifid_le             IF/ID load enable (0 = hold)
//   branch_taken, ta    branch redirect request and target address
//   instr_in            combinational ROM read data for address pc
//   pc, next_pc         fetch address to ROM and pc+4
//   ifid_instr/_next_pc/_valid   IF/ID pipeline register contents
//   fetch_state         00 FILL, 01 RUN, 10 STALL
//   fetch_count         saturating count of words captured into IF/ID
//   stall_count         saturating count of stalled cycles
module fetch_stage #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_e,
  input  logic             ifid_le,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  ta,
  input  logic [31:0]      instr_in,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  next_pc,
  output logic [31:0]      ifid_instr,
  output logic [PC_W-1:0]  ifid_next_pc,
  output logic             ifid_valid,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] next_pc;
    logic            valid;
  } ifid_t;

  localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Registered state
  logic [PC_W-1:0]  pc_q;
  ifid_t            ifid_q;
  state_t           state_q;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Next-state values
  logic [PC_W-1:0]  pc_d;
  ifid_t            ifid_d;
  state_t           state_d;
  logic [CNT_W-1:0] fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_d;

  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  branch_tgt;
  logic             flush;
  logic             word_captured;
  logic             stall_cycle;

  // Wraps modulo 2^PC_W by width truncation (252 -> 0 for PC_W=8).
  assign pc_plus4   = pc_q + PC_STEP;
  // Targets are forced word-aligned; the low two bits of ta are ignored.
  assign branch_tgt = {ta[PC_W-1:2], 2'b00};

`ifdef FLUSH_ON_BRANCH_EN
  // The word fetched alongside a taken branch is on the wrong path: squash it.
  assign flush = branch_taken & ifid_le;
`else
  // Delay-slot semantics: the word fetched with the branch is kept.
  assign flush = 1'b0;
`endif

  assign word_captured = ifid_le & ~flush;
  // A redirect moves the PC even with pc_e=0, so it is not a stalled cycle.
  assign stall_cycle   = ~pc_e & ~branch_taken;

  // PC: branch redirect beats the stall, stall beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_tgt;
    end else if (pc_e) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID: loads whenever enabled. With pc_e=1 and ifid_le=0 the PC still
  // advances and the current word is dropped silently.
  always_comb begin
    ifid_d = ifid_q;
    if (ifid_le) begin
      if (flush) begin
        ifid_d.instr = NOP_WORD;
        ifid_d.valid = 1'b0;
      end else begin
        ifid_d.instr = instr_in;
        ifid_d.valid = 1'b1;
      end
      ifid_d.next_pc = pc_plus4;
    end
  end

  // Saturating performance counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (word_captured && (fetch_cnt_q != CNT_MAX)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    end
    if (stall_cycle && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // Fetch FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (ifid_le) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!pc_e && !ifid_le && !branch_taken) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (pc_e || branch_taken) begin
          state_d = RUN;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Reset wins over everything, including a branch resolving on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= '0;
      ifid_q.instr   <= NOP_WORD;
      ifid_q.next_pc <= '0;
      ifid_q.valid   <= 1'b0;
      state_q        <= FILL;
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign next_pc      = pc_plus4;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_next_pc = ifid_q.next_pc;
  assign ifid_valid   = ifid_q.valid;
  assign fetch_state  = state_q;
  assign fetch_count  = fetch_cnt_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage with a behavioural model.
// The model advances once per clock edge from the applied inputs; a compare
// process checks every DUT output against it on each falling edge, and a few
// literal expectations pin specific scenario results.
module tb_fetch_stage;

  localparam int PC_W  = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             pc_e;
  logic             ifid_le;
  logic             branch_taken;
  logic [PC_W-1:0]  ta;
  logic [31:0]      instr_in;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  next_pc;
  logic [31:0]      ifid_instr;
  logic [PC_W-1:0]  ifid_next_pc;
  logic             ifid_valid;
  logic [1:0]       fetch_state;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;

  int tests = 0;
  int fails = 0;

  fetch_stage #(
    .PC_W     (PC_W),
    .CNT_W    (CNT_W),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_e         (pc_e),
    .ifid_le      (ifid_le),
    .branch_taken (branch_taken),
    .ta           (ta),
    .instr_in     (instr_in),
    .pc           (pc),
    .next_pc      (next_pc),
    .ifid_instr   (ifid_instr),
    .ifid_next_pc (ifid_next_pc),
    .ifid_valid   (ifid_valid),
    .fetch_state  (fetch_state),
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // ROM image: every address returns a distinct, recognisable word.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  assign instr_in = rom_word(pc);

  // Behavioural model (state 0=FILL, 1=RUN, 2=STALL).
  int          m_pc, m_ifid_npc, m_valid, m_state, m_fc, m_sc;
  logic [31:0] m_instr;
  bit          checking = 0;

  task automatic model_edge(input bit r, input bit pe, input bit le, input bit bt, input logic [7:0] t);
    bit squash;
    if (r) begin
      m_pc = 0; m_instr = 32'h0; m_ifid_npc = 0; m_valid = 0;
      m_state = 0; m_fc = 0; m_sc = 0;
    end else begin
      squash = 0;
`ifdef FLUSH_ON_BRANCH_EN
      squash = bt && le;
`endif
      if (le) begin
        m_instr    = squash ? 32'h0 : rom_word(m_pc[7:0]);
        m_valid    = squash ? 0 : 1;
        m_ifid_npc = (m_pc + 4) % 256;
      end
      if (le && !squash) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (!pe && !bt)    m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      case (m_state)
        0:       m_state = le ? 1 : 0;
        1:       m_state = (!pe && !le && !bt) ? 2 : 1;
        default: m_state = (pe || bt) ? 1 : 2;
      endcase
      if (bt)      m_pc = t - (t % 4);
      else if (pe) m_pc = (m_pc + 4) % 256;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, end #1 after it.
  task automatic step(input bit r, input bit pe, input bit le, input bit bt, input logic [7:0] t);
    @(negedge clk);
    reset = r; pc_e = pe; ifid_le = le; branch_taken = bt; ta = t;
    @(posedge clk);
    model_edge(r, pe, le, bt, t);
    checking = 1;
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("pc",           32'(pc),           32'(m_pc));
      chk("next_pc",      32'(next_pc),      32'((m_pc + 4) % 256));
      chk("ifid_instr",   ifid_instr,        m_instr);
      chk("ifid_next_pc", 32'(ifid_next_pc), 32'(m_ifid_npc));
      chk("ifid_valid",   32'(ifid_valid),   32'(m_valid));
      chk("fetch_state",  32'(fetch_state),  32'(m_state));
      chk("fetch_count",  32'(fetch_count),  32'(m_fc));
      chk("stall_count",  32'(stall_count),  32'(m_sc));
    end
  end

  logic [31:0] exp_br_instr;
  logic [31:0] exp_br_valid;

  initial begin
    reset = 1'b1; pc_e = 1'b0; ifid_le = 1'b0; branch_taken = 1'b0; ta = '0;

    // Reset for two cycles.
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_state", 32'(fetch_state), 32'h0);
    chk("rst_cnts", {16'(fetch_count), 16'(stall_count)}, 32'h0);

    // Four sequential fetches of W0..W3.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 8'h00);
    chk("run_pc", 32'(pc), 32'd16);
    chk("run_instr_w3", ifid_instr, 32'hC0DE_0CF3);
    chk("run_state", 32'(fetch_state), 32'h1);
    chk("run_fetch_count", 32'(fetch_count), 32'd4);

    // Redirect to 8, then stall three cycles there.
    step(0, 1, 1, 1, 8'h08);
    chk("redir_pc", 32'(pc), 32'h08);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00);
    chk("stall_pc", 32'(pc), 32'h08);
    chk("stall_state", 32'(fetch_state), 32'h2);
    chk("stall_count3", 32'(stall_count), 32'd3);

    // Release: pc moves on to 12.
    step(0, 1, 1, 0, 8'h00);
    chk("release_pc", 32'(pc), 32'd12);
    chk("release_state", 32'(fetch_state), 32'h1);
    chk("release_instr", ifid_instr, 32'hC0DE_08F7);

    // Taken branch at pc=12 with unaligned target 0x43.
    step(0, 1, 1, 1, 8'h43);
`ifdef FLUSH_ON_BRANCH_EN
    exp_br_instr = 32'h0000_0000; exp_br_valid = 32'h0;
`else
    exp_br_instr = 32'hC0DE_0CF3; exp_br_valid = 32'h1;
`endif
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_instr", ifid_instr, exp_br_instr);
    chk("br_valid", 32'(ifid_valid), exp_br_valid);

    // Stall, then a branch resolves during the stall.
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h20);
    chk("stbr_pc", 32'(pc), 32'h20);
    chk("stbr_instr", ifid_instr, exp_br_instr);
    chk("stbr_stall_count", 32'(stall_count), 32'd4);
    chk("stbr_state", 32'(fetch_state), 32'h1);

    // PC wrap: 248 -> 252 -> 0.
    step(0, 1, 1, 1, 8'hF8);
    step(0, 1, 1, 0, 8'h00);
    chk("wrap_pc252", 32'(pc), 32'hFC);
    step(0, 1, 1, 0, 8'h00);
    chk("wrap_pc0", 32'(pc), 32'h0);
    chk("wrap_ifid_npc", 32'(ifid_next_pc), 32'h0);
    chk("wrap_instr", ifid_instr, 32'hC0DE_FC03);

    // pc_e=1 with ifid_le=0: PC advances, IF/ID holds, word lost.
    step(0, 1, 0, 0, 8'h00);
    chk("lost_pc", 32'(pc), 32'h4);
    chk("lost_instr", ifid_instr, 32'hC0DE_FC03);

    // One more stall cycle, then reset with a branch pending.
    step(0, 0, 0, 0, 8'h00);
    chk("pre_rst_stall_count", 32'(stall_count), 32'd5);
    chk("pre_rst_state", 32'(fetch_state), 32'h2);
    step(1, 1, 1, 1, 8'h80);
    chk("midrst_pc", 32'(pc), 32'h0);
    chk("midrst_cnts", {16'(fetch_count), 16'(stall_count)}, 32'h0);
    chk("midrst_valid", 32'(ifid_valid), 32'h0);
    chk("midrst_state", 32'(fetch_state), 32'h0);

    // FILL with pc_e=0 stays FILL and counts a stall.
    step(0, 0, 0, 0, 8'h00);
    chk("fill_hold_state", 32'(fetch_state), 32'h0);
    // ifid_le=1 with pc_e=0 loads IF/ID and leaves FILL.
    step(0, 0, 1, 0, 8'h00);
    chk("fill_exit_state", 32'(fetch_state), 32'h1);

    // Counter saturation.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 8'h00);
    chk("fetch_sat", 32'(fetch_count), 32'(CMAX));
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'h00);
    chk("stall_sat", 32'(stall_count), 32'(CMAX));

    @(negedge clk);
    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
